// File: rtl/iwdg_wb_sequencer.sv
// Wishbone classic master that unlocks, configures, starts and then refreshes an IWDG slave.
// One bus transfer at a time; err aborts, rty re-issues, ack advances the sequence.
module iwdg_wb_sequencer #(
  parameter int unsigned GRL            = 1,
  parameter logic [31:0] BASE_ADR       = 32'h0100_0000,
  parameter int unsigned REFRESH_PERIOD = 0,
  parameter int unsigned POLL_MAX       = 255,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic         clk_m2s,
  input  logic         rst_m2s,
  input  logic         start,
  input  logic [2:0]   cfg_pr,
  input  logic [11:0]  cfg_rlr,
  input  logic         refresh_req,
  output logic [31:0]  adr_m2s,
  output logic [31:0]  dat_m2s,
  output logic [GRL:0] sel_m2s,
  output logic         cyc_m2s,
  output logic         stb_m2s,
  output logic         we_m2s,
  output logic         lok_m2s,
  input  logic [31:0]  dat_s2m,
  input  logic         ack_s2m,
  input  logic         err_s2m,
  input  logic         rty_s2m,
  output logic         busy,
  output logic         armed,
  output logic         error,
  output logic [15:0]  refresh_cnt
);

  localparam int unsigned CW      = 32;
  localparam bit          AUTO_EN = (REFRESH_PERIOD != 0);
  localparam logic [CW-1:0] TMR_LAST = AUTO_EN ? CW'(REFRESH_PERIOD - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_UNLOCK, S_WR_PR, S_WR_RLR, S_POLL, S_KICK, S_ARMED, S_REFRESH, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic [CW-1:0]   retry_q, retry_d, poll_q, poll_d, timer_q, timer_d;
  logic            pend_q, pend_d;
  logic [15:0]     rcnt_q, rcnt_d;
  logic [2:0]      pr_q, pr_d;
  logic [11:0]     rlr_q, rlr_d;
  logic            busy_q, busy_d, armed_q, armed_d, error_q, error_d;

  logic            is_bus, bus_we, term, tmr_exp;
  logic [3:0]      bus_off;
  logic [31:0]     bus_dat;
  state_e          nxt_st;
  logic            unused_dat;

  assign unused_dat = ^dat_s2m[31:2];
  assign term       = cyc_q && (ack_s2m || err_s2m || rty_s2m);
  assign tmr_exp    = AUTO_EN && (timer_q == TMR_LAST);

  // Transfer issued by each bus state and where its ack leads.
  always_comb begin
    is_bus  = 1'b0;
    bus_we  = 1'b1;
    bus_off = 4'h0;
    bus_dat = 32'h0;
    nxt_st  = state_q;
    case (state_q)
      S_UNLOCK:  begin is_bus = 1'b1; bus_dat = 32'h5555;     nxt_st = S_WR_PR;  end
      S_WR_PR:   begin is_bus = 1'b1; bus_off = 4'h4; bus_dat = 32'(pr_q);  nxt_st = S_WR_RLR; end
      S_WR_RLR:  begin is_bus = 1'b1; bus_off = 4'h8; bus_dat = 32'(rlr_q); nxt_st = S_POLL;   end
      S_POLL:    begin is_bus = 1'b1; bus_off = 4'hC; bus_we = 1'b0;        nxt_st = S_KICK;   end
      S_KICK:    begin is_bus = 1'b1; bus_dat = 32'hCCCC;     nxt_st = S_ARMED;  end
      S_REFRESH: begin is_bus = 1'b1; bus_dat = 32'hAAAA;     nxt_st = S_ARMED;  end
      default:   ;
    endcase
  end

  // Next-state logic for the sequence, bus handshake and refresh scheduling.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    retry_d = retry_q;
    poll_d  = poll_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    rcnt_d  = rcnt_q;
    pr_d    = pr_q;
    rlr_d   = rlr_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_UNLOCK;
          pr_d    = cfg_pr;
          rlr_d   = cfg_rlr;
          retry_d = '0;
          poll_d  = '0;
        end
      end
      S_ARMED: begin
        if (refresh_req || tmr_exp) pend_d = 1'b1;
        if (pend_q) begin
          // leaving now absorbs any request raised in this cycle
          state_d = S_REFRESH;
          pend_d  = 1'b0;
        end else if (AUTO_EN && !tmr_exp) begin
          timer_d = timer_q + CW'(1);
        end
      end
      default: begin
        if (is_bus && !cyc_q) begin
          cyc_d = 1'b1;
          we_d  = bus_we;
          adr_d = BASE_ADR + 32'(bus_off);
          dat_d = bus_dat;
        end else if (is_bus && term) begin
          cyc_d = 1'b0;
          if (err_s2m) begin
            state_d = S_ERROR;
          end else if (rty_s2m) begin
            if (retry_q == CW'(RETRY_MAX)) state_d = S_ERROR;
            else retry_d = retry_q + CW'(1);
          end else begin
            retry_d = '0;
            if (state_q == S_POLL && dat_s2m[1:0] != 2'b00) begin
              if (poll_q + CW'(1) >= CW'(POLL_MAX)) state_d = S_ERROR;
              else poll_d = poll_q + CW'(1);
            end else begin
              state_d = nxt_st;
              if (state_q == S_REFRESH) rcnt_d = rcnt_q + 16'd1;
              if (state_q == S_REFRESH || state_q == S_KICK) timer_d = '0;
            end
          end
        end
      end
    endcase
    busy_d  = !(state_d == S_IDLE || state_d == S_ARMED || state_d == S_ERROR);
    armed_d = (state_d == S_ARMED);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_m2s or posedge rst_m2s) begin
    if (rst_m2s) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      retry_q <= '0;
      poll_q  <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      rcnt_q  <= '0;
      pr_q    <= '0;
      rlr_q   <= '0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      retry_q <= retry_d;
      poll_q  <= poll_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      rcnt_q  <= rcnt_d;
      pr_q    <= pr_d;
      rlr_q   <= rlr_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
      error_q <= error_d;
    end
  end

  assign adr_m2s     = adr_q;
  assign dat_m2s     = dat_q;
  assign cyc_m2s     = cyc_q;
  assign stb_m2s     = cyc_q;
  assign we_m2s      = we_q;
  assign sel_m2s     = {(GRL+1){cyc_q}};
  assign lok_m2s     = 1'b0;
  assign busy        = busy_q;
  assign armed       = armed_q;
  assign error       = error_q;
  assign refresh_cnt = rcnt_q;

endmodule
